// File: rtl/sb_pkg.sv
// sb_pkg: shared framing constants and sequencer state encoding for the sideband link
package sb_pkg;
    localparam logic [7:0] DLE = 8'hFE;
    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h40;
    localparam int SYM_BITS = 10;
    typedef enum logic [2:0] {
        ST_IDLE, ST_DLE1, ST_STX, ST_PAY, ST_CRC_HI, ST_CRC_LO, ST_DLE2, ST_ETX
    } sb_state_t;
endpackage

// File: rtl/sb_sym_ser.sv
// sb_sym_ser: sends one byte as a 10-bit symbol (start, 8 data bits LSB-first, stop)
module sb_sym_ser #(
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic       run,
    input  logic [7:0] sym_byte,
    input  logic       sym_cov,
    output logic [3:0] cnt,
    output logic       ser_bit,
    output logic       crc_en,
    output logic       sym_end
);
    import sb_pkg::*;
    localparam logic [3:0] LAST = 4'(SYM_BITS - 1);
    logic [7:0] sh;
    logic       cov;
    logic [3:0] cnt_nxt;
    assign sym_end = cnt == LAST;
    assign cnt_nxt = sym_end ? 4'd0 : cnt + 4'd1;
    // Bit and crc_en are computed for the upcoming count so both leave flops aligned
    always_ff @(posedge sb_clk) begin
        if (rst || clr) begin
            cnt     <= '0;
            sh      <= '0;
            cov     <= 1'b0;
            ser_bit <= IDLE_LVL;
            crc_en  <= 1'b0;
        end else if (load) begin
            cnt     <= '0;
            sh      <= sym_byte;
            cov     <= sym_cov;
            ser_bit <= 1'b0;
            crc_en  <= 1'b0;
        end else if (run) begin
            cnt     <= cnt_nxt;
            ser_bit <= (cnt < 4'd8) ? sh[cnt[2:0]] : (cnt == 4'd8);
            crc_en  <= cov && (cnt < 4'd8);
        end
    end
endmodule

// File: rtl/sb_tx_frame_ctrl.sv
// sb_tx_frame_ctrl: frames payload as DLE STX payload CRC DLE ETX with DLE stuffing
module sb_tx_frame_ctrl #(
    parameter int   MAX_LEN  = 64,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic        sb_clk,
    input  logic        rst,
    input  logic [7:0]  payload_data,
    input  logic        payload_valid,
    input  logic        payload_last,
    output logic        payload_ready,
    input  logic [15:0] crc_value,
    output logic        crc_init,
    output logic        crc_en,
    output logic        crc_bit,
    output logic        tx_ser,
    output logic        busy,
    output logic        done,
    output logic        err_underrun,
    output logic        err_len
);
    import sb_pkg::*;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
    sb_state_t state, state_n;
    logic [7:0] byte_q, byte_n, crc_lo_q, crc_lo_n, ld_byte;
    logic [LW-1:0] len_q, len_n, len_inc;
    logic dup, dup_n, last_q, last_n, busy_n, init_n, ready_n, done_n, eu_n, el_n;
    logic ld, ld_cov, clr, stuff, ser_bit, sym_end;
    logic [3:0] cnt;
    sb_sym_ser #(.IDLE_LVL(IDLE_LVL)) u_ser (
        .sb_clk  (sb_clk),
        .rst     (rst),
        .clr     (clr),
        .load    (ld),
        .run     (state != ST_IDLE),
        .sym_byte(ld_byte),
        .sym_cov (ld_cov),
        .cnt     (cnt),
        .ser_bit (ser_bit),
        .crc_en  (crc_en),
        .sym_end (sym_end)
    );
    assign tx_ser  = ser_bit;
    assign crc_bit = ser_bit;
    assign stuff   = (byte_q == DLE) && !dup;
    assign len_inc = len_q + 1'b1;
    // State, frame bookkeeping and registered control pulses
    always_ff @(posedge sb_clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            byte_q        <= '0;
            crc_lo_q      <= '0;
            len_q         <= '0;
            dup           <= 1'b0;
            last_q        <= 1'b0;
            busy          <= 1'b0;
            crc_init      <= 1'b0;
            payload_ready <= 1'b0;
            done          <= 1'b0;
            err_underrun  <= 1'b0;
            err_len       <= 1'b0;
        end else begin
            state         <= state_n;
            byte_q        <= byte_n;
            crc_lo_q      <= crc_lo_n;
            len_q         <= len_n;
            dup           <= dup_n;
            last_q        <= last_n;
            busy          <= busy_n;
            crc_init      <= init_n;
            payload_ready <= ready_n;
            done          <= done_n;
            err_underrun  <= eu_n;
            err_len       <= el_n;
        end
    end
    // Symbol sequencing: ready is raised one count early so it sits on the stop bit of the
    // final copy of a byte; a stuffed DLE repeats uncovered before the next handshake
    always_comb begin
        state_n  = state;
        byte_n   = byte_q;
        crc_lo_n = crc_lo_q;
        len_n    = len_q;
        dup_n    = dup;
        last_n   = last_q;
        busy_n   = busy;
        init_n   = 1'b0;
        done_n   = 1'b0;
        eu_n     = 1'b0;
        el_n     = 1'b0;
        ld       = 1'b0;
        ld_byte  = byte_q;
        ld_cov   = 1'b0;
        clr      = 1'b0;
        ready_n  = (cnt == 4'd8) && (state == ST_STX || (state == ST_PAY && !stuff && !last_q));
        case (state)
            ST_IDLE: if (payload_valid) begin
                state_n = ST_DLE1;
                ld      = 1'b1;
                ld_byte = DLE;
                init_n  = 1'b1;
                busy_n  = 1'b1;
                len_n   = '0;
                last_n  = 1'b0;
                dup_n   = 1'b0;
            end
            ST_DLE1: if (sym_end) begin
                state_n = ST_STX;
                ld      = 1'b1;
                ld_byte = STX;
                ld_cov  = 1'b1;
            end
            ST_STX, ST_PAY: if (sym_end) begin
                if (payload_ready && payload_valid) begin
                    state_n = ST_PAY;
                    ld      = 1'b1;
                    ld_byte = payload_data;
                    ld_cov  = 1'b1;
                    byte_n  = payload_data;
                    dup_n   = 1'b0;
                    len_n   = len_inc;
                    last_n  = payload_last || len_inc == LEN_MAX;
                    el_n    = !payload_last && len_inc == LEN_MAX;
                end else if (payload_ready) begin
                    state_n = ST_IDLE;
                    clr     = 1'b1;
                    busy_n  = 1'b0;
                    eu_n    = 1'b1;
                end else if (stuff) begin
                    ld    = 1'b1;
                    dup_n = 1'b1;
                end else begin
                    state_n  = ST_CRC_HI;
                    ld       = 1'b1;
                    ld_byte  = crc_value[15:8];
                    byte_n   = crc_value[15:8];
                    crc_lo_n = crc_value[7:0];
                    dup_n    = 1'b0;
                end
            end
            ST_CRC_HI: if (sym_end) begin
                ld      = 1'b1;
                dup_n   = stuff;
                state_n = stuff ? ST_CRC_HI : ST_CRC_LO;
                ld_byte = stuff ? byte_q : crc_lo_q;
                byte_n  = stuff ? byte_q : crc_lo_q;
            end
            ST_CRC_LO: if (sym_end) begin
                ld      = 1'b1;
                dup_n   = stuff;
                state_n = stuff ? ST_CRC_LO : ST_DLE2;
                ld_byte = stuff ? byte_q : DLE;
            end
            ST_DLE2: if (sym_end) begin
                state_n = ST_ETX;
                ld      = 1'b1;
                ld_byte = ETX;
            end
            ST_ETX: if (sym_end) begin
                state_n = ST_IDLE;
                clr     = 1'b1;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end
endmodule
